// File: rtl/button_debounce_if.sv
// Button bundle between the board-facing pins and the debouncer.
// The slave side is the debouncer, and the master side is whoever drives the raw pins.
interface button_debounce_if #(
    parameter int width_p = 3
);
    logic [width_p-1:0] button_async_unsafe_i;
    logic [width_p-1:0] button_o;
    logic [width_p-1:0] rise_o;
    logic [width_p-1:0] fall_o;

    modport master (output button_async_unsafe_i, input button_o, rise_o, fall_o);
    modport slave  (input button_async_unsafe_i, output button_o, rise_o, fall_o);
endinterface

// File: rtl/button_debounce.sv
// Per-channel two-flop synchronizer plus stable-count debounce filter.
// BUTTON_DEBOUNCE_EDGE_EN builds registered rise/fall pulses; otherwise they are tied to 0.
module button_debounce_lane #(
    parameter int debounce_cycles_p = 120000,
    parameter int cnt_w_p           = $clog2(debounce_cycles_p + 1)
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam logic [cnt_w_p-1:0] last_c = cnt_w_p'(debounce_cycles_p - 1);

    logic               meta;
    logic               sync;
    logic [cnt_w_p-1:0] count;
    logic               differ;
    logic               accept;

    assign differ = (sync != level);
    assign accept = differ && (count == last_c);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    // Any return of sync to the accepted level restarts the count, so the count never wraps.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count <= '0;
            level <= 1'b0;
        end else if (!differ) begin
            count <= '0;
        end else if (accept) begin
            count <= '0;
            level <= sync;
        end else begin
            count <= count + cnt_w_p'(1);
        end
    end

`ifdef BUTTON_DEBOUNCE_EDGE_EN
    // Pulses are registered on the acceptance edge, so they line up with the new level.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= accept & sync;
            fall <= accept & ~sync;
        end
    end
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif
endmodule

module button_debounce #(
    parameter int width_p           = 3,
    parameter int debounce_cycles_p = 120000
) (
    input  logic             clk_i,
    input  logic             reset_i,
    button_debounce_if.slave bus
);
    localparam int cnt_w_c = $clog2(debounce_cycles_p + 1);

    for (genvar gi = 0; gi < width_p; gi++) begin : g_lane
        button_debounce_lane #(
            .debounce_cycles_p (debounce_cycles_p),
            .cnt_w_p           (cnt_w_c)
        ) u_lane (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .raw     (bus.button_async_unsafe_i[gi]),
            .level   (bus.button_o[gi]),
            .rise    (bus.rise_o[gi]),
            .fall    (bus.fall_o[gi])
        );
    end
endmodule

// File: tb/tb_button_debounce.sv
// Directed scoreboard bench for button_debounce (width_p=3, debounce_cycles_p=4).
// Expected pulses honour BUTTON_DEBOUNCE_EDGE_EN; without it rise/fall must stay 0.
module tb_button_debounce;
    localparam int W = 3;
    localparam int D = 4;

`ifdef BUTTON_DEBOUNCE_EDGE_EN
    localparam bit edge_en = 1'b1;
`else
    localparam bit edge_en = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    button_debounce_if #(.width_p(W)) bus ();

    button_debounce #(.width_p(W), .debounce_cycles_p(D)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] btn;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    task automatic cmp(input string name, input logic [W-1:0] b, input logic [W-1:0] r,
                       input logic [W-1:0] f);
        checks++;
        if ({bus.button_o, bus.rise_o, bus.fall_o} === {b, r, f}) passed++;
        else $display("FAIL %s @%0t: got btn=%b rise=%b fall=%b, want btn=%b rise=%b fall=%b",
                      name, $time, bus.button_o, bus.rise_o, bus.fall_o, b, r, f);
    endtask

    // Drive one cycle of inputs and queue what must be seen just after the next rising edge.
    task automatic step(input string name, input logic rst_v, input logic [W-1:0] raw,
                        input logic [W-1:0] b, input logic [W-1:0] r, input logic [W-1:0] f);
        exp_t e;
        @(negedge clk);
        rst = rst_v;
        bus.button_async_unsafe_i = raw;
        e.btn  = b;
        e.rise = edge_en ? r : '0;
        e.fall = edge_en ? f : '0;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic steps(input string name, input logic rst_v, input logic [W-1:0] raw,
                         input logic [W-1:0] b, input int n);
        for (int i = 0; i < n; i++) step(name, rst_v, raw, b, '0, '0);
    endtask

    task automatic async_reset(input string name);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 cmp(name, '0, '0, '0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp(e.name, e.btn, e.rise, e.fall);
            end
        end
    end

    initial begin : stim
        bus.button_async_unsafe_i = '1;
        #3 cmp("reset_async_init", '0, '0, '0);
        steps("reset_held", 1'b1, 3'b111, 3'b000, 3);

        // Button held through reset release counts as a fresh rise.
        steps("rel_wait",   1'b0, 3'b111, 3'b000, 5);
        step ("rel_accept", 1'b0, 3'b111, 3'b111, 3'b111, 3'b000);
        steps("rel_hold",   1'b0, 3'b111, 3'b111, 2);

        async_reset("reset_mid_high");
        steps("reset_clear", 1'b1, 3'b000, 3'b000, 2);

        // Short glitch on channel 0 never reaches the output.
        steps("glitch_hi", 1'b0, 3'b001, 3'b000, 3);
        steps("glitch_lo", 1'b0, 3'b000, 3'b000, 6);

        for (int t = 0; t < 20; t++)
            steps("toggle", 1'b0, (t % 2 == 0) ? 3'b010 : 3'b000, 3'b000, 1);
        steps("tog_wait",   1'b0, 3'b010, 3'b000, 5);
        step ("tog_accept", 1'b0, 3'b010, 3'b010, 3'b010, 3'b000);
        steps("tog_hold",   1'b0, 3'b010, 3'b010, 2);

        steps("ch2_rise_wait", 1'b0, 3'b110, 3'b010, 5);
        step ("ch2_rise",      1'b0, 3'b110, 3'b110, 3'b100, 3'b000);
        steps("ch2_rise_hold", 1'b0, 3'b110, 3'b110, 2);
        steps("ch2_fall_wait", 1'b0, 3'b010, 3'b110, 5);
        step ("ch2_fall",      1'b0, 3'b010, 3'b010, 3'b000, 3'b100);
        steps("ch2_fall_hold", 1'b0, 3'b010, 3'b010, 2);

        // Channel 0 rises while channel 1 falls on the same edge.
        steps("simul_wait", 1'b0, 3'b001, 3'b010, 5);
        step ("simul",      1'b0, 3'b001, 3'b001, 3'b001, 3'b010);
        steps("simul_hold", 1'b0, 3'b001, 3'b001, 2);

        // Channel 2 up at edge 0, channel 0 down two edges later: separate schedules.
        steps("stag_a",      1'b0, 3'b101, 3'b001, 2);
        steps("stag_b",      1'b0, 3'b100, 3'b001, 3);
        step ("stag_ch2",    1'b0, 3'b100, 3'b101, 3'b100, 3'b000);
        steps("stag_mid",    1'b0, 3'b100, 3'b101, 1);
        step ("stag_ch0",    1'b0, 3'b100, 3'b100, 3'b000, 3'b001);
        steps("stag_hold",   1'b0, 3'b100, 3'b100, 1);

        // Pending rise on channel 0 reaches count 2, then reset abandons it.
        steps("pend_count", 1'b0, 3'b101, 3'b100, 4);
        async_reset("reset_mid_count");
        steps("pend_rst",    1'b1, 3'b101, 3'b000, 1);
        steps("redo_wait",   1'b0, 3'b101, 3'b000, 5);
        step ("redo_accept", 1'b0, 3'b101, 3'b101, 3'b101, 3'b000);
        steps("redo_hold",   1'b0, 3'b101, 3'b101, 2);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        #3;
        if (sb.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
